// File: rtl/rf_pkg.sv
// Shared types and constants for the RF transceiver link controller.
package rf_pkg;

  typedef enum logic [1:0] {
    InstShortRd = 2'b00,
    InstShortWr = 2'b01,
    InstLongRd  = 2'b10,
    InstLongWr  = 2'b11
  } inst_e;

  typedef enum logic [2:0] {
    StRstLow,
    StRstSettle,
    StIdle,
    StIntRead,
    StRxRead,
    StTxLen,
    StTxData,
    StTxTrig
  } state_e;

  typedef enum logic [2:0] {
    AccIdle,
    AccSetup,
    AccStrobe,
    AccGap,
    AccWait
  } acc_state_e;

  localparam logic [9:0] AddrIntstat = 10'h031;
  localparam logic [9:0] AddrTxncon  = 10'h01B;

  localparam int unsigned AccSetupCyc  = 2;
  localparam int unsigned AccIgnoreCyc = 3;

  typedef struct packed {
    inst_e      inst;
    logic [9:0] addr;
    logic [7:0] data;
  } acc_req_t;

  function automatic acc_req_t mk_req(inst_e inst, logic [9:0] addr, logic [7:0] data);
    acc_req_t req;
    req.inst = inst;
    req.addr = addr;
    req.data = data;
    return req;
  endfunction

endpackage

// File: rtl/rf_access.sv
// Single transceiver access: setup hold, one-cycle strobe, ready blanking, then wait for ready.
module rf_access
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [1:0] i_inst,
  input  logic [9:0] i_addr,
  input  logic [7:0] i_wdata,
  input  logic       i_ready,
  input  logic [7:0] i_rd_data,
  output logic [9:0] o_addr,
  output logic [7:0] o_data,
  output logic [1:0] o_inst,
  output logic       o_cs,
  output logic       o_done,
  output logic [7:0] o_rdata
);

  acc_state_e r_state;
  logic [1:0] r_cnt;
  logic [9:0] r_addr;
  logic [7:0] r_data;
  logic [1:0] r_inst;
  logic       r_cs;
  logic [7:0] r_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= AccIdle;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_inst  <= '0;
      r_cs    <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_cs <= 1'b0;
      unique case (r_state)
        AccIdle: begin
          if (i_start) begin
            r_addr  <= i_addr;
            r_data  <= i_wdata;
            r_inst  <= i_inst;
            r_cnt   <= 2'(AccSetupCyc - 1);
            r_state <= AccSetup;
          end
        end
        AccSetup: begin
          if (r_cnt == 2'd0) begin
            r_cs    <= 1'b1;
            r_state <= AccStrobe;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        AccStrobe: begin
          r_cnt   <= 2'(AccIgnoreCyc - 1);
          r_state <= AccGap;
        end
        // The transceiver may still report idle right after the strobe; ignore it here.
        AccGap: begin
          if (r_cnt == 2'd0) begin
            r_state <= AccWait;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        AccWait: begin
          if (i_ready) begin
            r_rdata <= i_rd_data;
            r_state <= AccIdle;
          end
        end
        default: r_state <= AccIdle;
      endcase
    end
  end

  // Done is combinational so the caller can use the byte in the cycle it is sampled.
  assign o_done  = (r_state == AccWait) && i_ready;
  assign o_rdata = o_done ? i_rd_data : r_rdata;
  assign o_addr  = r_addr;
  assign o_data  = r_data;
  assign o_inst  = r_inst;
  assign o_cs    = r_cs;

endmodule

// File: rtl/rf_link_ctrl.sv
// RF transceiver link controller: power-up sequencing, interrupt-driven RX drain into a
// local buffer, and framed TX writes with length and trigger.
module rf_link_ctrl
  import rf_pkg::*;
#(
  parameter int unsigned RST_LOW_CYC    = 50000,
  parameter int unsigned RST_SETTLE_CYC = 110000,
  parameter int unsigned RX_LEN         = 8,
  parameter logic [9:0]  RX_BASE        = 10'h300,
  parameter logic [9:0]  TX_BASE        = 10'h000,
  parameter int unsigned TX_MAX         = 32,
  parameter int unsigned BUF_DEPTH      = 16
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] addr_out,
  output logic [7:0] data_out,
  output logic [1:0] inst,
  output logic       cs_out,
  input  logic       ready,
  input  logic [7:0] rd_data,
  input  logic       intr,
  output logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic [7:0] rx_drop
);

  localparam int unsigned PtrW = $clog2(BUF_DEPTH);

  state_e      r_state;
  logic [31:0] r_cnt;
  logic [6:0]  r_idx;
  logic [6:0]  r_ntx;
  logic        r_tx_end;
  logic        r_len_step;
  logic        r_pend;
  logic        r_start;
  acc_req_t    r_req;
  logic        r_tx_ready;
  logic        r_rst_n;

  logic [7:0]  r_mem [BUF_DEPTH];
  logic [PtrW:0] r_wr_ptr;
  logic [PtrW:0] r_rd_ptr;
  logic [7:0]  r_rx_drop;

  logic        w_done;
  logic [7:0]  w_rdata;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic        w_wr_en;

  rf_access u_access (
    .clk       (clk),
    .rst       (rst),
    .i_start   (r_start),
    .i_inst    (r_req.inst),
    .i_addr    (r_req.addr),
    .i_wdata   (r_req.data),
    .i_ready   (ready),
    .i_rd_data (rd_data),
    .o_addr    (addr_out),
    .o_data    (data_out),
    .o_inst    (inst),
    .o_cs      (cs_out),
    .o_done    (w_done),
    .o_rdata   (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StRstLow;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_ntx      <= '0;
      r_tx_end   <= 1'b0;
      r_len_step <= 1'b0;
      r_pend     <= 1'b0;
      r_start    <= 1'b0;
      r_req      <= '0;
      r_tx_ready <= 1'b0;
      r_rst_n    <= 1'b0;
    end else begin
      r_start <= 1'b0;
      unique case (r_state)
        StRstLow: begin
          if (r_cnt == RST_LOW_CYC - 1) begin
            r_cnt   <= '0;
            r_rst_n <= 1'b1;
            r_state <= StRstSettle;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        StRstSettle: begin
          if (r_cnt == RST_SETTLE_CYC - 1) begin
            r_cnt   <= '0;
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        StIdle: begin
          if (!intr) begin
            r_start <= 1'b1;
            r_pend  <= 1'b1;
            r_req   <= mk_req(InstShortRd, AddrIntstat, 8'h00);
            r_state <= StIntRead;
          end else if (tx_valid) begin
            r_ntx      <= '0;
            r_tx_ready <= 1'b1;
            r_state    <= StTxData;
          end
        end
        StIntRead: begin
          if (w_done) begin
            r_pend <= 1'b0;
            if (w_rdata[3]) begin
              r_idx   <= '0;
              r_state <= StRxRead;
            end else begin
              r_state <= StIdle;
            end
          end
        end
        StRxRead: begin
          if (!r_pend) begin
            r_start <= 1'b1;
            r_pend  <= 1'b1;
            r_req   <= mk_req(InstLongRd, RX_BASE + 10'(r_idx), 8'h00);
          end else if (w_done) begin
            r_pend <= 1'b0;
            if (r_idx == 7'(RX_LEN - 1)) begin
              r_state <= StIdle;
            end else begin
              r_idx <= r_idx + 7'd1;
            end
          end
        end
        StTxData: begin
          if (!r_pend) begin
            if (tx_valid && r_tx_ready) begin
              r_tx_ready <= 1'b0;
              r_start    <= 1'b1;
              r_pend     <= 1'b1;
              r_req      <= mk_req(InstLongWr, TX_BASE + 10'd2 + 10'(r_ntx), tx_data);
              r_ntx      <= r_ntx + 7'd1;
              r_tx_end   <= tx_last || (r_ntx == 7'(TX_MAX - 1));
            end
          end else if (w_done) begin
            r_pend <= 1'b0;
            if (r_tx_end) begin
              r_len_step <= 1'b0;
              r_state    <= StTxLen;
            end else begin
              r_tx_ready <= 1'b1;
            end
          end
        end
        // Two writes: byte count to TX_BASE+1, then a zero header byte to TX_BASE.
        StTxLen: begin
          if (!r_pend) begin
            r_start <= 1'b1;
            r_pend  <= 1'b1;
            if (r_len_step) begin
              r_req <= mk_req(InstLongWr, TX_BASE, 8'h00);
            end else begin
              r_req <= mk_req(InstLongWr, TX_BASE + 10'd1, 8'(r_ntx));
            end
          end else if (w_done) begin
            r_pend <= 1'b0;
            if (r_len_step) begin
              r_state <= StTxTrig;
            end else begin
              r_len_step <= 1'b1;
            end
          end
        end
        StTxTrig: begin
          if (!r_pend) begin
            r_start <= 1'b1;
            r_pend  <= 1'b1;
            r_req   <= mk_req(InstShortWr, AddrTxncon, 8'h01);
          end else if (w_done) begin
            r_pend  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign w_push  = (r_state == StRxRead) && r_pend && w_done;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PtrW] != r_rd_ptr[PtrW]) &&
                   (r_wr_ptr[PtrW-1:0] == r_rd_ptr[PtrW-1:0]);
  assign w_pop   = !w_empty && rx_ready;
  // A pop in the same cycle frees the slot, so a full buffer still accepts the byte.
  assign w_wr_en = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[PtrW-1:0]] <= w_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_rx_drop <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_wr_en && (r_rx_drop != 8'hFF)) begin
        r_rx_drop <= r_rx_drop + 8'd1;
      end
    end
  end

  assign rx_valid = !w_empty;
  assign rx_data  = r_mem[r_rd_ptr[PtrW-1:0]];
  assign rx_drop  = r_rx_drop;
  assign tx_ready = r_tx_ready;
  assign busy     = (r_state != StIdle);
  assign rst_n    = r_rst_n;

endmodule

// File: tb/tb_rf_link_ctrl.sv
// Scoreboard bench for rf_link_ctrl against a small transceiver model (shortened power-up).
module tb_rf_link_ctrl;

  localparam int unsigned RstLow    = 50;
  localparam int unsigned RstSettle = 110;
  localparam int unsigned TxMax     = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] addr_out;
  logic [7:0] data_out;
  logic [1:0] inst;
  logic       cs_out;
  logic       ready;
  logic [7:0] rd_data;
  logic       intr;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       busy;
  logic [7:0] rx_drop;

  int n_checks = 0;
  int n_fail   = 0;
  int cs_cnt   = 0;

  logic [31:0] exp_acc[$];
  logic [31:0] exp_rx[$];

  logic [7:0] intstat = 8'h00;
  logic [7:0] rx_mem[8];
  logic [7:0] model_byte;
  logic [2:0] ph = 3'd0;

  logic [31:0] hist1 = '0;
  logic [31:0] hist2 = '0;
  logic        prev_cs = 1'b0;

  rf_link_ctrl #(
    .RST_LOW_CYC    (RstLow),
    .RST_SETTLE_CYC (RstSettle),
    .RX_LEN         (8),
    .RX_BASE        (10'h300),
    .TX_BASE        (10'h000),
    .TX_MAX         (TxMax),
    .BUF_DEPTH      (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .addr_out (addr_out),
    .data_out (data_out),
    .inst     (inst),
    .cs_out   (cs_out),
    .ready    (ready),
    .rd_data  (rd_data),
    .intr     (intr),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_last  (tx_last),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .busy     (busy),
    .rx_drop  (rx_drop)
  );

  always #5 clk = ~clk;

  // Transceiver model: ready stays high (with junk data) through the blanking window,
  // drops for two cycles, then presents the real byte.
  always @(posedge clk) begin
    if (cs_out) ph <= 3'd1;
    else if (ph != 3'd0 && ph < 3'd6) ph <= ph + 3'd1;
  end

  always_comb begin
    model_byte = rx_mem[addr_out[2:0]];
    if (addr_out == 10'h031) model_byte = intstat;
  end

  assign ready   = !(ph == 3'd4 || ph == 3'd5);
  assign rd_data = (ph == 3'd6) ? model_byte : 8'hEE;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk(logic [1:0] i, logic [9:0] a, logic [7:0] d);
    return {12'h000, i, a, d};
  endfunction

  always @(negedge clk) begin
    logic [31:0] cur;
    cur = pk(inst, addr_out, inst[0] ? data_out : 8'h00);
    if (cs_out) begin
      cs_cnt++;
      check("cs_one_cycle", {31'b0, prev_cs}, 32'd0);
      check("setup_prev1", hist1, cur);
      check("setup_prev2", hist2, cur);
      if (exp_acc.size() == 0) check("unexpected_cs", cur, 32'hFFFF_FFFF);
      else check("access", cur, exp_acc.pop_front());
    end
    if (rx_valid && rx_ready) begin
      if (exp_rx.size() == 0) check("unexpected_rx", {24'h0, rx_data}, 32'hFFFF_FFFF);
      else check("rx_data", {24'h0, rx_data}, exp_rx.pop_front());
    end
    hist2   = hist1;
    hist1   = cur;
    prev_cs = cs_out;
  end

  task automatic wait_busy(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (busy) break;
    end
    check("busy_rise", {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (!busy) break;
    end
    check("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  task automatic rx_expect(input logic [7:0] stat, input logic [7:0] base, input bit keep);
    intstat = stat;
    for (int i = 0; i < 8; i++) rx_mem[i] = base + 8'(i);
    exp_acc.push_back(pk(2'b00, 10'h031, 8'h00));
    if (stat[3]) begin
      for (int i = 0; i < 8; i++) begin
        exp_acc.push_back(pk(2'b10, 10'h300 + 10'(i), 8'h00));
        if (keep) exp_rx.push_back({24'h0, base + 8'(i)});
      end
    end
  endtask

  task automatic rx_irq(input logic [7:0] stat, input logic [7:0] base, input bit keep);
    rx_expect(stat, base, keep);
    intr = 1'b0;
    wait_busy(10);
    intr = 1'b1;
    wait_idle(400);
  endtask

  task automatic tx_expect(input logic [7:0] first, input logic [7:0] step, input int n);
    int cnt = 0;
    for (int j = 0; j < n; j++) begin
      exp_acc.push_back(pk(2'b11, 10'h002 + 10'(cnt), first + 8'(j) * step));
      cnt++;
      if (j == n - 1 || cnt == TxMax) begin
        exp_acc.push_back(pk(2'b11, 10'h001, 8'(cnt)));
        exp_acc.push_back(pk(2'b11, 10'h000, 8'h00));
        exp_acc.push_back(pk(2'b01, 10'h01B, 8'h01));
        cnt = 0;
      end
    end
  endtask

  task automatic tx_send(input logic [7:0] first, input logic [7:0] step, input int n);
    bit got;
    tx_expect(first, step, n);
    for (int j = 0; j < n; j++) begin
      tx_data  = first + 8'(j) * step;
      tx_last  = (j == n - 1);
      tx_valid = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 400; k++) begin
        @(negedge clk);
        if (tx_ready) begin
          got = 1'b1;
          break;
        end
      end
      check("tx_accept", {31'b0, got}, 32'd1);
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    wait_idle(400);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int low_n;
    int start;
    bit got;

    rst = 1'b1; intr = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
    rx_ready = 1'b1;
    for (int i = 0; i < 8; i++) rx_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rst_n", {31'b0, rst_n}, 32'd0);
    check("rst_cs", {31'b0, cs_out}, 32'd0);
    check("rst_inst", {30'b0, inst}, 32'd0);
    check("rst_addr", {22'b0, addr_out}, 32'd0);
    check("rst_data", {24'b0, data_out}, 32'd0);
    check("rst_tx_ready", {31'b0, tx_ready}, 32'd0);
    check("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
    check("rst_rx_drop", {24'b0, rx_drop}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd1);

    // Power-up sequencing.
    rst = 1'b0;
    n = 0; low_n = 0;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      n++;
      if (rst_n && low_n == 0) low_n = n;
      if (!busy) break;
    end
    check("rst_n_low_cycles", 32'(low_n), RstLow);
    check("settle_cycles", 32'(n), RstLow + RstSettle);
    check("no_cs_during_powerup", 32'(cs_cnt), 32'd0);

    // Receive interrupt, bytes stream out in order.
    rx_irq(8'h08, 8'hA0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("rx_basic_drained", 32'(exp_rx.size()), 32'd0);
    check("rx_basic_drop", {24'b0, rx_drop}, 32'd0);

    // Status without RX flag: only the status read.
    rx_irq(8'hF7, 8'h00, 1'b0);

    // Overflow and saturation with the consumer stalled.
    rx_ready = 1'b0;
    rx_irq(8'h08, 8'h40, 1'b1);
    rx_irq(8'h08, 8'h50, 1'b1);
    check("full_drop_zero", {24'b0, rx_drop}, 32'd0);
    check("full_rx_valid", {31'b0, rx_valid}, 32'd1);
    rx_irq(8'h08, 8'h60, 1'b0);
    check("drop_eight", {24'b0, rx_drop}, 32'd8);
    for (int r = 0; r < 30; r++) rx_irq(8'h08, 8'h70, 1'b0);
    check("drop_248", {24'b0, rx_drop}, 32'd248);
    rx_irq(8'h08, 8'h80, 1'b0);
    check("drop_saturate", {24'b0, rx_drop}, 32'd255);
    rx_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("full_drained", 32'(exp_rx.size()), 32'd0);
    check("rx_valid_empty", {31'b0, rx_valid}, 32'd0);

    // Three-byte frame, then a frame longer than TX_MAX.
    tx_send(8'h11, 8'h11, 3);
    tx_send(8'h81, 8'h01, 6);
    check("tx_all_issued", 32'(exp_acc.size()), 32'd0);

    // Interrupt wins over a pending TX byte.
    rx_expect(8'h08, 8'hC0, 1'b1);
    tx_expect(8'h5A, 8'h00, 1);
    start = cs_cnt;
    intr = 1'b0; tx_valid = 1'b1; tx_data = 8'h5A; tx_last = 1'b1;
    wait_busy(10);
    intr = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (tx_ready) begin
        got = 1'b1;
        break;
      end
    end
    check("prio_tx_accept", {31'b0, got}, 32'd1);
    check("tx_ready_after_rx", 32'(cs_cnt - start), 32'd9);
    @(posedge clk); #1;
    tx_valid = 1'b0; tx_last = 1'b0;
    wait_idle(400);
    check("prio_all_issued", 32'(exp_acc.size()), 32'd0);

    // Reset in the middle of the fourth RX read.
    rx_ready = 1'b0;
    intstat = 8'h08;
    for (int i = 0; i < 8; i++) rx_mem[i] = 8'hD0 + 8'(i);
    exp_acc.push_back(pk(2'b00, 10'h031, 8'h00));
    for (int i = 0; i < 4; i++) exp_acc.push_back(pk(2'b10, 10'h300 + 10'(i), 8'h00));
    start = cs_cnt;
    intr = 1'b0;
    wait_busy(10);
    intr = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (cs_cnt == start + 5) break;
    end
    check("reached_read4", 32'(cs_cnt - start), 32'd5);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_rst_n", {31'b0, rst_n}, 32'd0);
    check("mid_rst_cs", {31'b0, cs_out}, 32'd0);
    check("mid_rst_rx_valid", {31'b0, rx_valid}, 32'd0);
    check("mid_rst_rx_drop", {24'b0, rx_drop}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (RstLow + RstSettle + 20) @(posedge clk);
    #1;
    check("no_cs_after_rst", 32'(cs_cnt - start), 32'd5);
    check("acc_queue_empty", 32'(exp_acc.size()), 32'd0);
    check("rx_queue_empty", 32'(exp_rx.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_link_ctrl.md
RF_LINK_CTRL -- requirements
Module: rf_link_ctrl

Interface
REQ-001 SHALL have parameter RST_LOW_CYC, default 50000, rst_n low-pulse length in clk cycles.
REQ-002 SHALL have parameter RST_SETTLE_CYC, default 110000, cycles after rst_n rises before the first access.
REQ-003 SHALL have parameter RX_LEN, default 8, bytes read from the transceiver RX FIFO per receive interrupt (1..64).
REQ-004 SHALL have parameter RX_BASE, default 'h300, long address of the first RX FIFO byte.
REQ-005 SHALL have parameter TX_BASE, default 'h000, long address of the TX FIFO.
REQ-006 SHALL have parameter TX_MAX, default 32, maximum payload bytes per frame (1..125).
REQ-007 SHALL have parameter BUF_DEPTH, default 16, local RX buffer depth (power of two, >=2).
REQ-008 One clock; reset asynchronous, active-high: clk in 1, system clock; rst in 1, asynchronous active-high reset.
REQ-009 Transceiver side: addr_out out 10, access address; data_out out 8, write data; inst out 2, access type (00 short rd, 01 short wr, 10 long rd, 11 long wr); cs_out out 1, one-cycle access strobe; ready in 1, interface idle; rd_data in 8, read result; intr in 1, transceiver interrupt (active-low); rst_n out 1, transceiver reset.
REQ-010 TX stream: tx_data in 8; tx_valid in 1; tx_last in 1, final payload byte; tx_ready out 1.
REQ-011 RX stream: rx_data out 8; rx_valid out 1; rx_ready in 1.
REQ-012 Status: busy out 1, FSM outside IDLE; rx_drop out 8, saturating count of bytes dropped on a full buffer.

Function
REQ-013 FSM states: RST_LOW, RST_SETTLE, IDLE, INT_READ, RX_READ, TX_LEN, TX_DATA, TX_TRIG.
REQ-014 RST_LOW: rst_n=0 for RST_LOW_CYC cycles -> RST_SETTLE: rst_n=1 for RST_SETTLE_CYC cycles -> IDLE.
REQ-015 Every access: addr/data/inst held stable 2 cycles, cs_out high exactly 1 cycle, then ignore ready 3 cycles, then wait ready=1; rd_data sampled on the cycle ready is first seen high.
REQ-016 IDLE priority: intr=0 beats tx_valid=1 when both asserted in the same cycle.
REQ-017 INT_READ: short read addr 'h31; if rd_data[3]=1 -> RX_READ, else -> IDLE.
REQ-018 RX_READ: RX_LEN long reads at RX_BASE+i, i=0..RX_LEN-1, 10-bit wrap; each byte pushed to local buffer the cycle it is sampled; then -> IDLE.
REQ-019 Buffer full on push: byte discarded, rx_drop increments, saturating at 255; read sequence continues.
REQ-020 rx_valid=1 whenever buffer non-empty; pop on rx_valid&rx_ready; simultaneous push and pop on a full buffer succeeds without drop.
REQ-021 TX: tx_ready=1 only in TX_DATA while the interface waits for a byte; each accepted byte long-written to TX_BASE+2+n.
REQ-022 TX_DATA ends on tx_last or after TX_MAX bytes (excess bytes not accepted until next frame); then TX_LEN long-writes n to TX_BASE+1 and 0 to TX_BASE; then TX_TRIG short-writes 'h01 to addr 'h1B -> IDLE.
REQ-023 State order for TX: IDLE -> TX_DATA -> TX_LEN -> TX_TRIG -> IDLE; intr ignored until IDLE.
REQ-024 busy=1 in every state except IDLE.

Reset
REQ-025 On rst: state RST_LOW, rst_n=0, cs_out=0, inst=00, addr_out=0, data_out=0, tx_ready=0, rx_valid=0, rx_drop=0, buffer empty, all counters 0.
REQ-026 rst asserted mid-access or mid-frame aborts it immediately; no cs_out pulse emitted after rst rises; partial TX frame discarded.

Structure
REQ-027 Shared package rf_pkg SHALL hold the inst encoding enum, the FSM state enum, and register address constants ('h31 INTSTAT, 'h1B TXNCON).
REQ-028 Access timing of REQ-015 SHALL live in sub-module rf_access (start/done handshake, captures rd_data); the local buffer may be inline.

Verification
REQ-029 Power-up: release rst -> rst_n low exactly 50000 cycles, first cs_out no earlier than 160000 cycles after rst release.
REQ-030 intr=0, model returns INTSTAT 'h08, RX bytes 'hA0..'hA7 -> eight long reads 'h300..'h307, rx_data streams 'hA0..'hA7 in order.
REQ-031 rx_ready=0, two receive interrupts, BUF_DEPTH=16, RX_LEN=8 -> 16 bytes held, rx_drop=0; third interrupt -> rx_drop=8.
REQ-032 3-byte frame 'h11,'h22,'h33 with tx_last on third -> writes 'h002..'h004, then 'h001='h03, 'h000='h00, then short write 'h1B='h01.
REQ-033 intr=0 and tx_valid=1 same cycle in IDLE -> INTSTAT read issued first, tx_ready stays 0 until RX sequence completes.
REQ-034 rst pulsed during RX_READ access 4 -> no further cs_out, rst_n=0 next cycle, rx_valid=0, rx_drop=0.
